alu_multicycle: RTL and testbench

Parametrised, registered successor to the datapath ALU.
- Widens the operand path to WIDTH bits and extends ALUK to 3 bits (XOR, shifts, iterative multiply).
- Registers the result and condition codes (NZP, carry).
- Uses a Start/Busy/Done handshake so the control FSM can issue single-cycle ops and stall on the multi-cycle multiply.
- Sits between the SR1/SR2MUX operand path and the bus driver / NZP logic.

---
 rtl/alu_multicycle.sv | 159 +++++++++++++++
 tb/tb_alu_multicycle.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered ALU with a Start/Busy/Done handshake: single-cycle logic/arith/shift
// ops complete on the sampling edge; MUL runs a fixed WIDTH-iteration shift-add.
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       ALUK,
    input  logic [WIDTH-1:0] SR1_in,
    input  logic [WIDTH-1:0] SR2_in,
    output logic [WIDTH-1:0] ALU_result,
    output logic             Done,
    output logic             Busy,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             Carry
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_AND = 3'b001, OP_OR  = 3'b010, OP_NOT = 3'b011,
        OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
    } op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               n_q, n_d, z_q, z_d, p_q, p_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   op_result;
    logic [WIDTH-1:0]   acc_sum;
    logic [SHAMT_W-1:0] shamt;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic               load_carry;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b1;
            p_q      <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            p_q      <= p_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statements can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start && op_e'(ALUK) == OP_MUL) state_d = S_MUL;
            S_MUL:   if (cnt_q == CNT_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sum       = {1'b0, SR1_in} + {1'b0, SR2_in};
        shamt     = SR2_in[SHAMT_W-1:0];
        op_result = '0;
        case (op_e'(ALUK))
            OP_ADD:  op_result = sum[WIDTH-1:0];
            OP_AND:  op_result = SR1_in & SR2_in;
            OP_OR:   op_result = SR1_in | SR2_in;
            OP_NOT:  op_result = ~SR1_in;
            OP_XOR:  op_result = SR1_in ^ SR2_in;
            OP_SHL:  op_result = SR1_in << shamt;
            OP_SHR:  op_result = SR1_in >> shamt;
            default: op_result = '0;
        endcase

        acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        load_val   = '0;
        load_carry = 1'b0;

        if (state_q == S_IDLE && Start) begin
            if (op_e'(ALUK) == OP_MUL) begin
                mcand_d  = SR1_in;
                mplier_d = SR2_in;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                load       = 1'b1;
                load_val   = op_result;
                load_carry = (op_e'(ALUK) == OP_ADD) ? sum[WIDTH] : 1'b0;
            end
        end else if (state_q == S_MUL) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                load     = 1'b1;
                load_val = acc_sum;
            end
        end

        result_d = result_q;
        n_d      = n_q;
        z_d      = z_q;
        p_d      = p_q;
        carry_d  = carry_q;
        done_d   = load;
        if (load) begin
            result_d = load_val;
            n_d      = load_val[WIDTH-1];
            z_d      = (load_val == '0);
            p_d      = !load_val[WIDTH-1] && (load_val != '0);
            carry_d  = load_carry;
        end
    end

    assign ALU_result = result_q;
    assign Done       = done_q;
    assign Busy       = (state_q == S_MUL);
    assign N          = n_q;
    assign Z          = z_q;
    assign P          = p_q;
    assign Carry      = carry_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=16 and WIDTH=8: a driver pushes
// model predictions (value, flags, completion cycle); a monitor pops on Done.
module tb_alu_multicycle;
    logic Clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic        s16 = 1'b0, s8 = 1'b0;
    logic [2:0]  k16 = '0, k8 = '0;
    logic [15:0] a16 = '0, b16 = '0, r16;
    logic [7:0]  a8 = '0, b8 = '0, r8;
    logic        dn16, by16, n16, z16, p16, c16;
    logic        dn8, by8, n8, z8, p8, c8;

    alu_multicycle #(.WIDTH(16)) dut16 (
        .Clk(Clk), .Reset_n(rst_n), .Start(s16), .ALUK(k16), .SR1_in(a16), .SR2_in(b16),
        .ALU_result(r16), .Done(dn16), .Busy(by16), .N(n16), .Z(z16), .P(p16), .Carry(c16)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset_n(rst_n), .Start(s8), .ALUK(k8), .SR1_in(a8), .SR2_in(b8),
        .ALU_result(r8), .Done(dn8), .Busy(by8), .N(n8), .Z(z8), .P(p8), .Carry(c8)
    );

    typedef struct {
        logic [31:0] res;
        logic        n, z, p, c;
        int          done_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   busy_until[2];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wid(input int g);
        return (g == 0) ? 16 : 8;
    endfunction

    // Reference: plain wide arithmetic, truncated to w bits.
    task automatic model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic c);
        longint unsigned m, la, lb, s;
        int sh;
        m  = (64'd1 << w) - 1;
        la = a & m;
        lb = b & m;
        sh = int'(lb % w);
        s  = 0;
        c  = 1'b0;
        case (op)
            3'd0: begin s = la + lb; c = ((s >> w) & 1) != 0; end
            3'd1: s = la & lb;
            3'd2: s = la | lb;
            3'd3: s = ~la;
            3'd4: s = la ^ lb;
            3'd5: s = la << sh;
            3'd6: s = la >> sh;
            default: s = la * lb;
        endcase
        res = 32'(s & m);
    endtask

    // Drive one Start cycle; called at #1 after a falling edge.
    task automatic issue(input int g, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] r;
        logic c;
        int w;
        w = wid(g);
        if (g == 0) begin s16 = 1'b1; k16 = op; a16 = a[15:0]; b16 = b[15:0]; end
        else        begin s8  = 1'b1; k8  = op; a8  = a[7:0];  b8  = b[7:0];  end
        if (cyc >= busy_until[g]) begin
            model(w, op, a, b, r, c);
            e.res = r;
            e.n   = r[w-1];
            e.z   = (r == 0);
            e.p   = !e.n && !e.z;
            e.c   = c;
            e.done_cyc    = cyc + 1 + ((op == 3'd7) ? w : 0);
            busy_until[g] = e.done_cyc;
            if (g == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(negedge Clk); #1;
        s16 = 1'b0;
        s8  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk); #1;
            a16 = 16'($urandom); b16 = 16'($urandom); k16 = 3'($urandom);
            a8  = 8'($urandom);  b8  = 8'($urandom);  k8  = 3'($urandom);
        end
    endtask

    task automatic mon(input int g);
        logic d, b, n, z, p, c;
        logic [31:0] r;
        exp_t e;
        int has, w;
        string tag;
        w = wid(g);
        tag = $sformatf("w%0d_cyc%0d", w, cyc);
        if (g == 0) begin d = dn16; b = by16; n = n16; z = z16; p = p16; c = c16; r = 32'(r16); has = q0.size(); end
        else        begin d = dn8;  b = by8;  n = n8;  z = z8;  p = p8;  c = c8;  r = 32'(r8);  has = q1.size(); end
        check({"busy_", tag}, b, (cyc < busy_until[g]));
        check({"nzp_onehot_", tag}, n + z + p, 1);
        if (d) begin
            check({"done_expected_", tag}, (has > 0), 1);
            if (has > 0) begin
                e = (g == 0) ? q0.pop_front() : q1.pop_front();
                check({"result_", tag}, r, e.res);
                check({"flags_nzp_", tag}, {n, z, p}, {e.n, e.z, e.p});
                check({"carry_", tag}, c, e.c);
                check({"done_cycle_", tag}, cyc, e.done_cyc);
            end
        end else if (has > 0) begin
            e = (g == 0) ? q0[0] : q1[0];
            if (cyc >= e.done_cyc) begin
                check({"done_missing_", tag}, d, 1);
                if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge Clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        busy_until[0] = 0;
        busy_until[1] = 0;
        #2 rst_n = 1'b0;
        @(negedge Clk); @(negedge Clk); #1;
        rst_n = 1'b1;
        check("reset_r16", r16, 0);
        check("reset_nzp16", {n16, z16, p16}, 3'b010);
        check("reset_c16_dn16_by16", {c16, dn16, by16}, 3'b000);
        check("reset_r8", r8, 0);
        check("reset_nzp8", {n8, z8, p8}, 3'b010);
        idle(2);

        // ADD overflow into sign, then carry-out with zero result
        issue(0, 3'd0, 32'h7FFF, 32'h0001);
        check("add_7fff_1", {r16, n16, c16}, {16'h8000, 1'b1, 1'b0});
        issue(0, 3'd0, 32'hFFFF, 32'h0001);
        check("add_ffff_1", {r16, z16, c16}, {16'h0000, 1'b1, 1'b1});
        idle(2);

        // back-to-back single-cycle ops
        issue(0, 3'd3, 32'h00FF, 32'h1234);
        issue(0, 3'd4, 32'hAAAA, 32'hFFFF);
        check("xor_b2b", {r16, p16, dn16}, {16'h5555, 1'b1, 1'b1});
        issue(0, 3'd1, 32'hF0F0, 32'h0FF0);
        issue(0, 3'd2, 32'hF0F0, 32'h0FF0);
        check("or_b2b", {r16, dn16}, {16'hFFF0, 1'b1});
        idle(2);

        // shifts: amount uses low SHAMT bits only
        issue(0, 3'd5, 32'h8001, 32'd1);
        check("shl_1", r16, 16'h0002);
        issue(0, 3'd6, 32'h8000, 32'd17);
        check("shr_17", r16, 16'h4000);
        issue(0, 3'd5, 32'h1234, 32'd0);
        check("shl_0", r16, 16'h1234);
        idle(2);

        // multiply latency and wraparound
        issue(0, 3'd7, 32'h0012, 32'h0034);
        idle(16);
        check("mul_12_34", {r16, dn16}, {16'h03A8, 1'b1});
        idle(1);
        issue(0, 3'd7, 32'hFFFF, 32'hFFFF);
        idle(16);
        check("mul_ffff_ffff", {r16, p16}, {16'h0001, 1'b1});
        idle(2);

        // Start during MUL ignored; Start in the Done cycle accepted
        issue(0, 3'd7, 32'd3, 32'd5);
        idle(3);
        issue(0, 3'd0, 32'd1, 32'd1);
        for (int i = 0; i < 40 && cyc < busy_until[0]; i++) idle(1);
        check("t5_done_at_reissue", dn16, 1);
        check("t5_mul_kept", r16, 16'd15);
        issue(0, 3'd0, 32'd2, 32'd3);
        check("t5_add_after_done", r16, 16'd5);
        idle(2);

        // reset mid-multiply
        issue(0, 3'd7, 32'h00AB, 32'h00CD);
        idle(6);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        busy_until[0] = 0;
        busy_until[1] = 0;
        #1;
        check("midmul_reset_r16", r16, 0);
        check("midmul_reset_flags", {n16, z16, p16, c16, dn16, by16}, 6'b010000);
        @(negedge Clk); #1;
        rst_n = 1'b1;
        idle(24);

        // narrow instance
        issue(1, 3'd0, 32'h7F, 32'h01);
        check("w8_add_7f_1", {r8, n8, c8}, {8'h80, 1'b1, 1'b0});
        issue(1, 3'd0, 32'hFF, 32'h01);
        check("w8_add_ff_1", {r8, z8, c8}, {8'h00, 1'b1, 1'b1});
        issue(1, 3'd7, 32'h12, 32'h0D);
        idle(8);
        check("w8_mul_12_0d", {r8, dn8}, {8'hEA, 1'b1});
        idle(2);

        // randomized traffic, including starts while busy
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0)
                issue(int'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom);
            else
                idle(1);
        end
        idle(40);
        check("drain_w16", q0.size(), 0);
        check("drain_w8", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
